sumador_serial_ctrl: RTL and testbench
======================================

Name: sumador_serial_ctrl

Overview:
- Bit-serial adder controller: time-shares a single full-adder cell (S = A^B^C, Co = (A^B)&C | A&B) across WIDTH clock cycles to add two WIDTH-bit operands plus carry-in.
- Sequences operand shifting, carry storage and result assembly.
- Sits between operand switches/registers and result display logic in the lab datapath.
- start/busy/done handshake.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 1..16.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request a new addition; sampled only in IDLE
- A  input  WIDTH  operand A, captured on the accepting edge
- B  input  WIDTH  operand B, captured on the accepting edge
- Cin  input  1  carry-in, captured on the accepting edge
- S  output  WIDTH  registered sum of last completed operation
- Co  output  1  registered carry-out of last completed operation
- busy  output  1  high while in SUMA
- done  output  1  one-cycle pulse, high while in FIN

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: at any rising edge with rst=1, go to IDLE. Set S=0, Co=0, busy=0, done=0, bit counter=0, carry register=0, operand shift registers=0. rst overrides start and any in-flight operation. A partial result is discarded and never appears on S.
- States: IDLE, SUMA, FIN.
- IDLE: busy=0, done=0. At an edge with start=1 (call it edge k):
  - load shift_a<=A, shift_b<=B, carry<=Cin, cnt<=0
  - go to SUMA
  - start=0 keeps the block in IDLE.
- SUMA: busy=1. At each edge:
  - bit s = shift_a[0]^shift_b[0]^carry
  - carry <= (shift_a[0]^shift_b[0])&carry | shift_a[0]&shift_b[0]
  - shift_a and shift_b shift right one position
  - s enters the MSB of the internal sum shift register, which shifts right
  - cnt increments
- End of SUMA: at the edge where cnt==WIDTH-1 (edge k+WIDTH):
  - S <= fully assembled sum, including the bit computed on this edge
  - Co <= new carry
  - go to FIN
- FIN: done=1, busy=0 for exactly one cycle. Next edge returns unconditionally to IDLE. start during FIN is ignored.
- Latency: done is high during the cycle after edge k+WIDTH. Minimum start-to-start period is WIDTH+2 cycles. With start held high continuously, a new operation is accepted every WIDTH+2 edges.
- start during SUMA is ignored. A, B and Cin changes after edge k do not affect the running operation.
- S and Co hold their previous values through IDLE and SUMA. They change only on the edge entering FIN or on reset.
- busy and done are never high simultaneously.
- WIDTH=1: SUMA lasts exactly one cycle; the result is a single full-adder evaluation.
- cnt width is clog2(WIDTH), minimum 1 bit. No wrap-around occurs, because SUMA exits at WIDTH-1.

Test Plan:
- WIDTH=4, A=0101, B=0011, Cin=0, start pulsed at edge k → busy=1 for 4 cycles; at edge k+4, S=1000, Co=0; done=1 for exactly one cycle, then 0.
- WIDTH=4, A=1111, B=0001, Cin=0 → S=0000, Co=1. Then A=1111, B=1111, Cin=1 → S=1111, Co=1. The previous S/Co hold unchanged throughout SUMA of the second operation.
- start pulsed again 2 cycles into SUMA with different operands → ignored. Original result is delivered and done pulses once. Then hold start=1 continuously: done pulses every 6 cycles.
- rst=1 at cycle 2 of SUMA (A=0111, B=0001) → next edge: IDLE, S=0, Co=0, busy=0, done=0. No done pulse follows. A fresh start then yields the correct S=1000, Co=0.
- Change A/B/Cin every cycle during SUMA after capturing A=1010, B=0101, Cin=1 → S=0000, Co=1 (captured values only).
- WIDTH=1 instance: A=1, B=1, Cin=1 → S=1, Co=1, done during the cycle after edge k+1. Exhaustive 8-input sweep matches the full-adder equations.

Source files
------------

// File: rtl/sumador_serial_ctrl.sv
// Bit-serial adder controller.
// A single full-adder cell is reused over WIDTH cycles. Each cycle it consumes
// the LSBs of the operand shift registers and the stored carry.
// The sum bits are assembled MSB-first into a shift register.
module sumador_serial_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUMA = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift_a;
    logic [WIDTH-1:0] r_shift_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_co;
    logic             r_busy;
    logic             r_done;

    logic             w_a0;
    logic             w_b0;
    logic             w_s;
    logic             w_co;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_next;

    // Shared full-adder cell and next value of the sum assembly register.
    // The shift form is used so that WIDTH=1 needs no special case.
    assign w_a0       = r_shift_a[0];
    assign w_b0       = r_shift_b[0];
    assign w_s        = w_a0 ^ w_b0 ^ r_carry;
    assign w_co       = ((w_a0 ^ w_b0) & r_carry) | (w_a0 & w_b0);
    assign w_sum_next = (r_sum >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    // Control FSM with the datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift_a <= '0;
            r_shift_b <= '0;
            r_sum     <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_s       <= '0;
            r_co      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_shift_a <= A;
                        r_shift_b <= B;
                        r_carry   <= Cin;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= SUMA;
                    end
                end
                SUMA: begin
                    r_carry   <= w_co;
                    r_shift_a <= r_shift_a >> 1;
                    r_shift_b <= r_shift_b >> 1;
                    r_sum     <= w_sum_next;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        // The result includes the bit and carry produced on this edge.
                        r_s     <= w_sum_next;
                        r_co    <= w_co;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign S    = r_s;
    assign Co   = r_co;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_sumador_serial_ctrl.sv
// Directed self-checking bench for sumador_serial_ctrl (WIDTH=4 and WIDTH=1).
module tb_sumador_serial_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, cin4;
    logic [3:0] a4, b4, s4;
    logic       co4, busy4, done4;
    logic       start1, cin1;
    logic [0:0] a1, b1, s1;
    logic       co1, busy1, done1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sumador_serial_ctrl #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .Cin(cin4),
        .S(s4), .Co(co4), .busy(busy4), .done(done4)
    );

    sumador_serial_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .Cin(cin1),
        .S(s1), .Co(co1), .busy(busy1), .done(done1)
    );

    // Advance one rising edge; observations and input updates happen 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Run one WIDTH=4 addition starting from IDLE and check the whole timeline.
    task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [3:0] es, input logic ec);
        logic [3:0] s_prev;
        logic       co_prev;
        s_prev  = s4;
        co_prev = co4;
        a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_busy"}, 32'(busy4), 32'd1);
            check({tag, "_hold_s"}, 32'(s4), 32'(s_prev));
            check({tag, "_hold_co"}, 32'(co4), 32'(co_prev));
            if (i < 3) tick();
        end
        tick();
        check({tag, "_done"}, 32'(done4), 32'd1);
        check({tag, "_busy_fin"}, 32'(busy4), 32'd0);
        check({tag, "_s"}, 32'(s4), 32'(es));
        check({tag, "_co"}, 32'(co4), 32'(ec));
        tick();
        check({tag, "_done_low"}, 32'(done4), 32'd0);
    endtask

    initial begin
        int done_cnt;
        int done_at [3];
        logic [1:0] exp1;

        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        tick();
        tick();
        check("rst_s4", 32'(s4), 32'd0);
        check("rst_co4", 32'(co4), 32'd0);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_done4", 32'(done4), 32'd0);
        check("rst_s1", 32'(s1), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        rst = 1'b0;
        tick();

        // Basic additions, results held through the following operation.
        op4("t1", 4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0);
        op4("t2a", 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1);
        op4("t2b", 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1);

        // start during SUMA is ignored.
        a4 = 4'b0010; b4 = 4'b0011; cin4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        start4 = 1'b1; a4 = 4'b1111; b4 = 4'b1111; cin4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        check("t3_done", 32'(done4), 32'd1);
        check("t3_s", 32'(s4), 32'd5);
        check("t3_co", 32'(co4), 32'd0);
        tick();
        check("t3_done_low", 32'(done4), 32'd0);
        check("t3_idle", 32'(busy4), 32'd0);
        tick();
        check("t3_no_restart", 32'(busy4), 32'd0);

        // start held high: one result every 6 edges.
        a4 = 4'b0001; b4 = 4'b0001; cin4 = 1'b0; start4 = 1'b1;
        tick();
        done_cnt = 0;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (done4 === 1'b1) begin
                if (done_cnt < 3) done_at[done_cnt] = i;
                done_cnt++;
            end
            if (busy4 === 1'b1 && done4 === 1'b1) check("t3_busy_done_excl", 32'd1, 32'd0);
        end
        check("t3_pulse_count", 32'(done_cnt), 32'd3);
        check("t3_pulse0", 32'(done_at[0]), 32'd4);
        check("t3_pulse1", 32'(done_at[1]), 32'd10);
        check("t3_pulse2", 32'(done_at[2]), 32'd16);
        check("t3_s_stream", 32'(s4), 32'd2);
        start4 = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("t3_drained", 32'(busy4), 32'd0);

        // Reset in the middle of SUMA discards the partial result.
        a4 = 4'b0111; b4 = 4'b0001; cin4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_s", 32'(s4), 32'd0);
        check("t4_co", 32'(co4), 32'd0);
        check("t4_busy", 32'(busy4), 32'd0);
        check("t4_done", 32'(done4), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done4 !== 1'b0 || busy4 !== 1'b0) done_cnt++;
        end
        check("t4_quiet", 32'(done_cnt), 32'd0);
        check("t4_s_quiet", 32'(s4), 32'd0);
        op4("t4_fresh", 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0);

        // Input changes after capture do not disturb the operation.
        a4 = 4'b1010; b4 = 4'b0101; cin4 = 1'b1; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
            tick();
        end
        a4 = 4'b0000; b4 = 4'b0000; cin4 = 1'b0;
        tick();
        check("t5_done", 32'(done4), 32'd1);
        check("t5_s", 32'(s4), 32'd0);
        check("t5_co", 32'(co4), 32'd1);
        tick();

        // WIDTH=1: one-cycle SUMA, then exhaustive full-adder sweep.
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("w1_busy", 32'(busy1), 32'd1);
        tick();
        check("w1_done", 32'(done1), 32'd1);
        check("w1_s", 32'(s1), 32'd1);
        check("w1_co", 32'(co1), 32'd1);
        tick();
        check("w1_done_low", 32'(done1), 32'd0);
        for (int v = 0; v < 8; v++) begin
            a1 = 1'(v >> 2); b1 = 1'(v >> 1); cin1 = 1'(v);
            exp1 = 2'(32'(a1) + 32'(b1) + 32'(cin1));
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            tick();
            check($sformatf("w1_sweep%0d_done", v), 32'(done1), 32'd1);
            check($sformatf("w1_sweep%0d_sum", v), 32'({co1, s1}), 32'(exp1));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
